// File: rtl/rfsoc_gpio_cfg_ctrl_pkg.sv
// Shared GPIO bit map, default sizes and FSM state encoding for the
// RFSoC GPIO configuration controller.
package rfsoc_config;

    localparam int unsigned GPIO_W          = 8;
    localparam int unsigned GPIO_SDATA      = 0;
    localparam int unsigned GPIO_MASK_CLK   = 1;
    localparam int unsigned GPIO_SEL_CLK    = 2;
    localparam int unsigned GPIO_CNT_CLK    = 3;
    localparam int unsigned GPIO_MUX_CLK    = 4;
    localparam int unsigned GPIO_USED       = 5;

    localparam int unsigned DEF_NUM_CH      = 16;
    localparam int unsigned DEF_MASK_W      = 16;
    localparam int unsigned DEF_CNT_W       = 256;
    localparam int unsigned DEF_QUIET_CYC   = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_RUN,
        ST_COMMIT
    } cfg_state_e;

endpackage

// File: rtl/rfsoc_gpio_cfg_ctrl_sync_edge.sv
// Two-flop synchroniser with a third delayed copy for rising-edge detection.
module rfsoc_gpio_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise_out
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/rfsoc_gpio_cfg_ctrl.sv
// PS GPIO bit-banged configuration receiver: serial shift into staging, atomic commit
// once the bus is quiet and no run is active. Optional macro: RFSOC_CFG_LEN_CHECK_EN.
module rfsoc_gpio_cfg_ctrl
    import rfsoc_config::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned MASK_W    = DEF_MASK_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned QUIET_CYC = DEF_QUIET_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [GPIO_W-1:0]        gpio_in,
    input  logic                     run_active,
    output logic [NUM_CH-1:0]        sel_out,
    output logic [NUM_CH*MASK_W-1:0] mask_out,
    output logic [NUM_CH-1:0]        mux_out,
    output logic [CNT_W-1:0]         cycle_count_out,
    output logic                     cfg_commit,
    output logic                     cfg_pending
`ifdef RFSOC_CFG_LEN_CHECK_EN
    ,
    output logic                     cfg_len_err
`endif
);

    localparam int unsigned QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

    logic [GPIO_USED-1:0] gpio_sync, gpio_rise;
    logic sdata, mask_edge, sel_edge, cnt_edge, mux_edge, any_edge;

    rfsoc_gpio_sync_edge #(.W(GPIO_USED)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (gpio_in[GPIO_USED-1:0]),
        .sync_out (gpio_sync),
        .rise_out (gpio_rise)
    );

    assign sdata     = gpio_sync[GPIO_SDATA];
    assign mask_edge = gpio_rise[GPIO_MASK_CLK];
    assign sel_edge  = gpio_rise[GPIO_SEL_CLK];
    assign cnt_edge  = gpio_rise[GPIO_CNT_CLK];
    assign mux_edge  = gpio_rise[GPIO_MUX_CLK];
    assign any_edge  = mask_edge | sel_edge | cnt_edge | mux_edge;

    // Spare GPIO pins, the sdata "edge" and the synced clock levels carry no function.
    logic unused_bits;
    assign unused_bits = ^{gpio_in[GPIO_W-1:GPIO_USED], gpio_rise[GPIO_SDATA],
                           gpio_sync[GPIO_USED-1:GPIO_SDATA+1]};

    cfg_state_e                     state_q, state_d;
    logic [QW-1:0]                  quiet_q, quiet_d;
    logic [NUM_CH-1:0]              sel_sr_q, sel_sr_d;
    logic [NUM_CH-1:0][MASK_W-1:0]  mask_stg_q, mask_stg_d;
    logic [NUM_CH-1:0]              mux_stg_q, mux_stg_d;
    logic [CNT_W-1:0]               cnt_stg_q, cnt_stg_d;
    logic [NUM_CH-1:0][MASK_W-1:0]  mask_out_q, mask_out_d;
    logic [NUM_CH-1:0]              mux_out_q, mux_out_d;
    logic [CNT_W-1:0]               cnt_out_q, cnt_out_d;
    logic                           commit_q, commit_d;
    logic                           pending_q, pending_d;

`ifdef RFSOC_CFG_LEN_CHECK_EN
    localparam int unsigned LEN_W = 16;
    logic [LEN_W-1:0] sel_cnt_q, sel_cnt_d;
    logic [LEN_W-1:0] mask_cnt_q, mask_cnt_d;
    logic [LEN_W-1:0] cc_cnt_q, cc_cnt_d;
    logic             len_err_q, len_err_d;
    logic             len_bad;

    assign len_bad = ((cc_cnt_q != '0) && (cc_cnt_q != LEN_W'(CNT_W))) ||
                     ((mask_cnt_q != '0) && ((mask_cnt_q % LEN_W'(MASK_W)) != '0));

    // The sel edge count is tracked alongside the others but does not gate the error.
    logic unused_sel_cnt;
    assign unused_sel_cnt = ^sel_cnt_q;
`endif

    always_comb begin
        state_d    = state_q;
        quiet_d    = quiet_q;
        sel_sr_d   = sel_sr_q;
        mask_stg_d = mask_stg_q;
        mux_stg_d  = mux_stg_q;
        cnt_stg_d  = cnt_stg_q;
        mask_out_d = mask_out_q;
        mux_out_d  = mux_out_q;
        cnt_out_d  = cnt_out_q;
        commit_d   = 1'b0;
        pending_d  = pending_q;

        if (sel_edge)
            sel_sr_d = {sel_sr_q[NUM_CH-2:0], sdata};
        // Mask and mux writes steer with the select value from before this cycle's shift.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_sr_q[i]) begin
                if (mask_edge)
                    mask_stg_d[i] = {mask_stg_q[i][MASK_W-2:0], sdata};
                if (mux_edge)
                    mux_stg_d[i] = sdata;
            end
        end
        if (cnt_edge)
            cnt_stg_d = {cnt_stg_q[CNT_W-2:0], sdata};
        if (any_edge)
            pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (any_edge) begin
                    state_d = ST_SHIFT;
                    quiet_d = '0;
                end
            end
            ST_SHIFT: begin
                if (any_edge)
                    quiet_d = '0;
                else if (quiet_q == QUIET_LAST)
                    state_d = ST_WAIT_RUN;
                else
                    quiet_d = quiet_q + 1'b1;
            end
            ST_WAIT_RUN: begin
                if (any_edge) begin
                    state_d = ST_SHIFT;
                    quiet_d = '0;
                end else if (!run_active) begin
                    state_d    = ST_COMMIT;
                    mask_out_d = mask_stg_q;
                    mux_out_d  = mux_stg_q;
                    cnt_out_d  = cnt_stg_q;
                    commit_d   = 1'b1;
                    pending_d  = 1'b0;
                end
            end
            ST_COMMIT: begin
                if (any_edge) begin
                    state_d = ST_SHIFT;
                    quiet_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef RFSOC_CFG_LEN_CHECK_EN
    always_comb begin
        sel_cnt_d  = sel_cnt_q;
        mask_cnt_d = mask_cnt_q;
        cc_cnt_d   = cc_cnt_q;
        len_err_d  = len_err_q;
        if (commit_d) begin
            len_err_d  = len_err_q | len_bad;
            sel_cnt_d  = '0;
            mask_cnt_d = '0;
            cc_cnt_d   = '0;
        end else begin
            if (sel_edge && (sel_cnt_q != '1))
                sel_cnt_d = sel_cnt_q + 1'b1;
            if (mask_edge && (mask_cnt_q != '1))
                mask_cnt_d = mask_cnt_q + 1'b1;
            if (cnt_edge && (cc_cnt_q != '1))
                cc_cnt_d = cc_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            quiet_q    <= '0;
            sel_sr_q   <= '0;
            mask_stg_q <= '0;
            mux_stg_q  <= '0;
            cnt_stg_q  <= '0;
            mask_out_q <= '0;
            mux_out_q  <= '0;
            cnt_out_q  <= '0;
            commit_q   <= 1'b0;
            pending_q  <= 1'b0;
`ifdef RFSOC_CFG_LEN_CHECK_EN
            sel_cnt_q  <= '0;
            mask_cnt_q <= '0;
            cc_cnt_q   <= '0;
            len_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            quiet_q    <= quiet_d;
            sel_sr_q   <= sel_sr_d;
            mask_stg_q <= mask_stg_d;
            mux_stg_q  <= mux_stg_d;
            cnt_stg_q  <= cnt_stg_d;
            mask_out_q <= mask_out_d;
            mux_out_q  <= mux_out_d;
            cnt_out_q  <= cnt_out_d;
            commit_q   <= commit_d;
            pending_q  <= pending_d;
`ifdef RFSOC_CFG_LEN_CHECK_EN
            sel_cnt_q  <= sel_cnt_d;
            mask_cnt_q <= mask_cnt_d;
            cc_cnt_q   <= cc_cnt_d;
            len_err_q  <= len_err_d;
`endif
        end
    end

    assign sel_out         = sel_sr_q;
    assign mask_out        = mask_out_q;
    assign mux_out         = mux_out_q;
    assign cycle_count_out = cnt_out_q;
    assign cfg_commit      = commit_q;
    assign cfg_pending     = pending_q;
`ifdef RFSOC_CFG_LEN_CHECK_EN
    assign cfg_len_err     = len_err_q;
`endif

endmodule

// File: tb/tb_rfsoc_gpio_cfg_ctrl.sv
// Scoreboard bench for rfsoc_gpio_cfg_ctrl: directed serial sequences push expected
// commits; a negedge monitor checks every cfg_commit pulse against the queue.
`timescale 1ns/1ps
module tb_rfsoc_gpio_cfg_ctrl;
    import rfsoc_config::*;

    localparam int unsigned NUM_CH    = 16;
    localparam int unsigned MASK_W    = 16;
    localparam int unsigned CNT_W     = 256;
    localparam int unsigned QUIET_CYC = 64;
    localparam int unsigned LAT       = 3 + QUIET_CYC + 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [7:0]               gpio_in = '0;
    logic                     run_active = 1'b0;
    logic [NUM_CH-1:0]        sel_out;
    logic [NUM_CH*MASK_W-1:0] mask_out;
    logic [NUM_CH-1:0]        mux_out;
    logic [CNT_W-1:0]         cycle_count_out;
    logic                     cfg_commit;
    logic                     cfg_pending;
`ifdef RFSOC_CFG_LEN_CHECK_EN
    logic                     cfg_len_err;
`endif

    rfsoc_gpio_cfg_ctrl #(
        .NUM_CH    (NUM_CH),
        .MASK_W    (MASK_W),
        .CNT_W     (CNT_W),
        .QUIET_CYC (QUIET_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gpio_in         (gpio_in),
        .run_active      (run_active),
        .sel_out         (sel_out),
        .mask_out        (mask_out),
        .mux_out         (mux_out),
        .cycle_count_out (cycle_count_out),
        .cfg_commit      (cfg_commit),
        .cfg_pending     (cfg_pending)
`ifdef RFSOC_CFG_LEN_CHECK_EN
        ,
        .cfg_len_err     (cfg_len_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_rise = 0;

    typedef struct {
        logic [NUM_CH*MASK_W-1:0] mask;
        logic [NUM_CH-1:0]        mux;
        logic [CNT_W-1:0]         cnt;
        int                       cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cfg_commit === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit cycle=%0d actual=commit required=none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("commit_mask", 256'(mask_out), 256'(e.mask));
                chk("commit_mux", 256'(mux_out), 256'(e.mux));
                chk("commit_cnt", 256'(cycle_count_out), 256'(e.cnt));
                chk("commit_cycle", 256'(cyc), 256'(e.cyc));
                chk("commit_pending_clr", 256'(cfg_pending), 256'(0));
            end
        end
    end

    task automatic send_bit(input int unsigned pin, input logic val);
        gpio_in[GPIO_SDATA] = val;
        repeat (4) @(negedge clk);
        gpio_in[pin] = 1'b1;
        last_rise = cyc;
        repeat (4) @(negedge clk);
        gpio_in[pin] = 1'b0;
    endtask

    task automatic send_word(input int unsigned pin, input logic [255:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--)
            send_bit(pin, val[i]);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL commit_timeout actual=%0d_outstanding required=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        repeat (3) @(negedge clk);
        chk("reset_mask", 256'(mask_out), 256'(0));
        chk("reset_mux", 256'(mux_out), 256'(0));
        chk("reset_cnt", 256'(cycle_count_out), 256'(0));
        chk("reset_sel", 256'(sel_out), 256'(0));
        chk("reset_commit", 256'(cfg_commit), 256'(0));
        chk("reset_pending", 256'(cfg_pending), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // A: select channel 2, load mask 0xA5A5
        send_word(GPIO_SEL_CLK, 256'h0004, 16);
        chk("A_pending", 256'(cfg_pending), 256'(1));
        chk("A_sel_out", 256'(sel_out), 256'h0004);
        send_word(GPIO_MASK_CLK, 256'hA5A5, 16);
        e.mask = '0;
        e.mask[2*MASK_W +: MASK_W] = 16'hA5A5;
        e.mux = '0;
        e.cnt = '0;
        e.cyc = last_rise + LAT;
        sb_q.push_back(e);
        chk("A_mask_hold", 256'(mask_out), 256'(0));
        drain(200);
        chk("A_pending_after", 256'(cfg_pending), 256'(0));

        // B: 256-bit cycle count of 1000
        send_word(GPIO_CNT_CLK, 256'd1000, 256);
        chk("B_pending", 256'(cfg_pending), 256'(1));
        e.cnt = 256'd1000;
        e.cyc = last_rise + LAT;
        sb_q.push_back(e);
        while (cyc < last_rise + LAT - 2) @(negedge clk);
        chk("B_pending_late", 256'(cfg_pending), 256'(1));
        chk("B_cnt_hold", 256'(cycle_count_out), 256'(0));
        drain(200);

        // C: sel 0x8001, mux=1, commit held off by run_active
        run_active = 1'b1;
        send_word(GPIO_SEL_CLK, 256'h8001, 16);
        send_bit(GPIO_MUX_CLK, 1'b1);
        repeat (500) @(negedge clk);
        chk("C_mux_hold", 256'(mux_out), 256'(0));
        chk("C_pending_hold", 256'(cfg_pending), 256'(1));
        e.mux = 16'h8001;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        run_active = 1'b0;
        drain(20);

        // D: reset in the middle of a mask shift, then a full sequence
        send_word(GPIO_MASK_CLK, 256'hFF, 8);
        rst_n = 1'b0;
        gpio_in = '0;
        #1;
        chk("D_rst_mask", 256'(mask_out), 256'(0));
        chk("D_rst_mux", 256'(mux_out), 256'(0));
        chk("D_rst_cnt", 256'(cycle_count_out), 256'(0));
        chk("D_rst_sel", 256'(sel_out), 256'(0));
        chk("D_rst_pending", 256'(cfg_pending), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(GPIO_SEL_CLK, 256'h0002, 16);
        send_word(GPIO_MASK_CLK, 256'h1234, 16);
        send_bit(GPIO_MUX_CLK, 1'b1);
        e.mask = '0;
        e.mask[1*MASK_W +: MASK_W] = 16'h1234;
        e.mux = 16'h0002;
        e.cnt = '0;
        e.cyc = last_rise + LAT;
        sb_q.push_back(e);
        drain(200);

`ifdef RFSOC_CFG_LEN_CHECK_EN
        chk("E_len_err_clean", 256'(cfg_len_err), 256'(0));
        send_word(GPIO_CNT_CLK, 256'd1000, 255);
        e.cnt = 256'd1000;
        e.cyc = last_rise + LAT;
        sb_q.push_back(e);
        drain(200);
        chk("E_len_err_set", 256'(cfg_len_err), 256'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfsoc_gpio_cfg_ctrl.md
Name: rfsoc_gpio_cfg_ctrl

Overview:
- Receives the PS-driven GPIO configuration bus: shared sdata plus four bit-banged serial clocks (mask_clk, sel_clk, cycle_count_clk, mux_set_clk).
- Synchronises the bus, detects serial-clock rising edges and shifts sdata into staging registers for the channel(s) chosen by a one-hot select register.
- Commits staging to the active outputs atomically once the bus has gone quiet and no waveform run is in progress.
- Sits between the PS GPIO and the per-channel waveform players.

Parameters:
- NUM_CH, 16, channel count; equals the width of the one-hot select register.
- MASK_W, 16, per-channel begin/end mask width in bits.
- CNT_W, 256, run cycle-count register width.
- QUIET_CYC, 64, idle clk cycles after the last serial edge before a commit is attempted.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous, active-low reset.
- gpio_in  in  8  raw PS GPIO, asynchronous to clk; bit indices come from the shared package.
- run_active  in  1  high while any channel is playing; blocks commit.
- sel_out  out  NUM_CH  current one-hot select shift register (debug).
- mask_out  out  NUM_CH*MASK_W  committed masks; channel i occupies bits [i*MASK_W +: MASK_W].
- mux_out  out  NUM_CH  committed per-channel mux state.
- cycle_count_out  out  CNT_W  committed run cycle count.
- cfg_commit  out  1  one-cycle pulse when staging is copied to the outputs.
- cfg_pending  out  1  high from the first serial edge until the commit completes.

Behaviour:
- Reset values: all outputs 0; all staging registers 0; FSM in IDLE.
- Synchronisation: gpio_in passes through a 2-flop synchroniser. Each serial clock has a third registered copy; an edge is sync & ~prev. Edge-to-shift latency is 3 clk cycles after gpio_in changes.
- sdata sampling: sdata is sampled from the synchronised stage in the same cycle the edge is detected. The PS must hold sdata stable for at least 4 clk cycles around each clock edge.
- sel_clk edge: sel_sr <= {sel_sr[NUM_CH-2:0], sdata}. One-hot is not enforced; multiple set bits write several channels at once.
- mask_clk edge: for every i with sel_sr[i]=1, mask_stg[i] <= {mask_stg[i][MASK_W-2:0], sdata}.
- mux_set_clk edge: for every i with sel_sr[i]=1, mux_stg[i] <= sdata.
- cycle_count_clk edge: cnt_stg <= {cnt_stg[CNT_W-2:0], sdata}. This register is global and ignores sel.
- Simultaneous edges in one cycle: all are processed. The mask and mux writes use the pre-shift sel_sr value.
- sel_sr = 0: mask and mux edges have no effect but still count as activity.
- FSM states:
  - IDLE: any edge -> SHIFT; cfg_pending=1.
  - SHIFT: quiet counter resets to 0 on every edge. When it reaches QUIET_CYC-1 -> WAIT_RUN.
  - WAIT_RUN: an edge returns to SHIFT. If run_active=0 and there is no edge -> COMMIT. Otherwise hold.
  - COMMIT: copies all staging to the outputs in one cycle, pulses cfg_commit, clears cfg_pending, -> IDLE.
- Commit latency after the final edge: QUIET_CYC+1 cycles with run_active low.
- Outputs change only in COMMIT; they are never partially updated. Staging is not cleared by a commit, so unshifted fields keep their previous staged value.
- Reset mid-shift: staging, outputs and FSM all return to reset values immediately.
- Quiet counter width is $clog2(QUIET_CYC); it saturates and does not wrap.

Optional Feature:
- Macro: RFSOC_CFG_LEN_CHECK_EN.
- When defined: per-register edge counters (sel, mask, cycle_count) count edges since the last commit. Extra output cfg_len_err (1 bit) is set at COMMIT if the cycle_count edge count is nonzero and not equal to CNT_W, or the mask edge count is nonzero and not a multiple of MASK_W. The error is sticky until reset and does not block the commit.
- When undefined: no counters and no cfg_len_err port.

Decomposition:
- Package rfsoc_config holds the GPIO bit-index localparams (sdata=0, mask_clk=1, sel_clk=2, cycle_count_clk=3, mux_set_clk=4), the default NUM_CH/MASK_W/CNT_W, and the FSM state enum typedef.
- One sub-module, rfsoc_gpio_sync_edge: a parameterised-width 2-flop synchroniser plus rising-edge detector, instantiated once for gpio_in.

Test Plan:
- Shift sel=16'h0004, then 16 mask_clk bits 0xA5A5, then wait 65 cycles with run_active=0 -> mask_out[2*16+:16]=16'hA5A5, other channels 0, one cfg_commit pulse.
- Shift 256 cycle_count bits with value 1000 -> cycle_count_out=1000 exactly QUIET_CYC+1 cycles after the last edge; cfg_pending high throughout.
- Finish shifting with run_active=1 held for 500 cycles -> outputs unchanged, cfg_pending=1; commit occurs 1 cycle after run_active falls.
- sel=16'h8001, mux_set_clk with sdata=1 -> mux_out=16'h8001 after commit.
- Assert rst_n low mid-way through a mask shift -> all outputs 0, cfg_pending=0; a subsequent full sequence commits correctly.
- With RFSOC_CFG_LEN_CHECK_EN defined: 255 cycle_count edges then quiet -> commit occurs and cfg_len_err=1.
